// File: rtl/attribute_result_queue_pkg.sv
// Shared packet-analyzer definitions: attribute word geometry and field offsets.
package attribute_result_queue_pkg;
  localparam int ATTRIBUTE_DATA_WIDTH_DEF = 135;
  localparam int QUEUE_ADDR_WIDTH_DEF     = 4;
  localparam int DROP_CNT_WIDTH_DEF       = 32;

  localparam int ATTR_PORT_MASK_LSB = 0;
  localparam int ATTR_PORT_MASK_W   = 64;
  localparam int ATTR_PRIORITY_LSB  = 64;
  localparam int ATTR_PRIORITY_W    = 8;
  localparam int ATTR_FLAGS_LSB     = 72;
  localparam int ATTR_FLAGS_W       = 63;
endpackage

// File: rtl/attribute_queue_ram.sv
// Simple dual-port distributed RAM: synchronous write, registered write-first read.
module attribute_queue_ram
  import attribute_result_queue_pkg::*;
#(
  parameter int DATA_W = ATTRIBUTE_DATA_WIDTH_DEF,
  parameter int ADDR_W = QUEUE_ADDR_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write-first bypass so an entry written at the same edge it becomes the read target is seen.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (we_i && (waddr_i == raddr_i)) rdata_q <= wdata_i;
    else                              rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/attribute_result_queue.sv
// Drop-on-full attribute queue with registered head, occupancy and drop statistics.
module attribute_result_queue
  import attribute_result_queue_pkg::*;
#(
  parameter int ATTRIBUTE_DATA_WIDTH = ATTRIBUTE_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH           = QUEUE_ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH            = DROP_CNT_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_i,
  input  logic [ATTRIBUTE_DATA_WIDTH-1:0] data_i,
  output logic                            m_valid,
  output logic [ATTRIBUTE_DATA_WIDTH-1:0] m_data,
  input  logic                            m_ready,
  input  logic                            clear_stats,
  output logic [ADDR_WIDTH:0]             occupancy,
  output logic [ADDR_WIDTH:0]             high_watermark,
  output logic [CNT_WIDTH-1:0]            drop_count,
  output logic                            overflow
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [ADDR_WIDTH-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]             occ_q, occ_d, hwm_q, hwm_d;
  logic [CNT_WIDTH-1:0]            drop_q, drop_d;
  logic                            ovf_q, m_valid_q, m_valid_d;
  logic [ATTRIBUTE_DATA_WIDTH-1:0] m_data_q, m_data_d, ram_rdata;
  logic pop, full, push, drop, ram_empty, head_from_in, head_from_ram, ram_we;

  // The head register is the oldest entry; the RAM holds everything behind it.
  always_comb begin
    pop           = m_valid_q & m_ready;
    full          = (occ_q == DEPTH);
    push          = valid_i & (~full | pop);
    drop          = valid_i & full & ~pop;
    ram_empty     = (occ_q == {{ADDR_WIDTH{1'b0}}, m_valid_q});
    head_from_in  = push & (~m_valid_q | (pop & ram_empty));
    head_from_ram = pop & ~ram_empty;
    ram_we        = push & ~head_from_in;

    wr_ptr_d  = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, ram_we};
    rd_ptr_d  = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, head_from_ram};
    occ_d     = occ_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
    m_valid_d = (occ_d != '0);

    m_data_d = m_data_q;
    if (head_from_ram)     m_data_d = ram_rdata;
    else if (head_from_in) m_data_d = data_i;

    if (clear_stats) begin
      hwm_d  = occ_d;
      drop_d = {{(CNT_WIDTH-1){1'b0}}, drop};
    end else begin
      hwm_d  = (occ_d > hwm_q) ? occ_d : hwm_q;
      drop_d = drop ? sat_inc(drop_q) : drop_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      hwm_q     <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      hwm_q     <= hwm_d;
      drop_q    <= drop_d;
      ovf_q     <= drop;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  // Read address runs one step ahead so the RAM output always shows the entry behind the head.
  attribute_queue_ram #(
    .DATA_W(ATTRIBUTE_DATA_WIDTH),
    .ADDR_W(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;
  assign occupancy      = occ_q;
  assign high_watermark = hwm_q;
  assign drop_count     = drop_q;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_attribute_result_queue.sv
// Randomized bench for attribute_result_queue against a queue-based reference model.
module tb_attribute_result_queue;
  localparam int DW    = 135;
  localparam int AW    = 4;
  localparam int CW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          clear_stats;
  logic [AW:0]   occupancy;
  logic [AW:0]   high_watermark;
  logic [CW-1:0] drop_count;
  logic          overflow;

  attribute_result_queue #(
    .ATTRIBUTE_DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_i        (valid_i),
    .data_i         (data_i),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .clear_stats    (clear_stats),
    .occupancy      (occupancy),
    .high_watermark (high_watermark),
    .drop_count     (drop_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [DW-1:0] mq[$];
  int            m_hwm, m_drop;
  bit            m_ovf;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [159:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_hwm  = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_outputs();
    check("m_valid", DW'(m_valid), DW'(mq.size() > 0));
    if (mq.size() > 0) check("m_data", m_data, mq[0]);
    check("occupancy", DW'(occupancy), DW'(mq.size()));
    check("high_watermark", DW'(high_watermark), DW'(m_hwm));
    check("drop_count", DW'(drop_count), DW'(m_drop));
    check("overflow", DW'(overflow), DW'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit rdy, input bit clr);
    bit pop, full, push, drop;
    valid_i     = v;
    data_i      = d;
    m_ready     = rdy;
    clear_stats = clr;
    @(posedge clk);
    pop  = (mq.size() > 0) && rdy;
    full = (mq.size() == DEPTH);
    push = v && (!full || pop);
    drop = v && full && !pop;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(d);
    if (clr) begin
      m_drop = drop ? 1 : 0;
      m_hwm  = mq.size();
    end else begin
      if (drop && m_drop < (1 << CW) - 1) m_drop++;
      if (mq.size() > m_hwm) m_hwm = mq.size();
    end
    m_ovf = drop;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; data_i = '0; m_ready = 1'b0; clear_stats = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_m_valid", DW'(m_valid), '0);
    check("rst_m_data", m_data, '0);
    check("rst_occupancy", DW'(occupancy), '0);
    check("rst_drop_count", DW'(drop_count), '0);
    reset = 1'b0;

    // A,B,C streamed through with the consumer always ready
    step(1'b1, 135'hA, 1'b1, 1'b0);
    step(1'b1, 135'hB, 1'b1, 1'b0);
    step(1'b1, 135'hC, 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

    // 18 pushes into a stalled queue, then drain
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    drain();

    // Full queue with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b1, rnd_word(), 1'b1, 1'b0);
    step(1'b1, rnd_word(), 1'b1, 1'b0);
    drain();

    // Alternating back-pressure with continuous pushes
    for (int i = 0; i < 40; i++) step(1'b1, rnd_word(), i[0] == 1'b0, 1'b0);
    drain();

    // Drop counter saturation, then clear coinciding with a drop
    for (int i = 0; i < DEPTH; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    for (int i = 0; i < (1 << CW) + 3; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b1, rnd_word(), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    drain();

    // Asynchronous reset partway through a drain
    for (int i = 0; i < 8; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    valid_i = 1'b0; m_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_m_valid", DW'(m_valid), '0);
    check("async_occupancy", DW'(occupancy), '0);
    check("async_hwm", DW'(high_watermark), '0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 135'h5EED, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rnd_word(), $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
